// File: rtl/tap_controller_if.sv
// Serial test-port bundle between the TAP controller and the JTAG logic around it.
// The slave side is the TAP controller; the master side drives TMS/TDI/DR_TDO.
interface tap_controller_if #(
    parameter int IR_WIDTH = 3
);
    logic                TMS;
    logic                TDI;
    logic                DR_TDO;
    logic [IR_WIDTH-1:0] I_CODE;
    logic [3:0]          TAP_STATE;
    logic                CAPTURE_DR;
    logic                SHIFT_DR;
    logic                UPDATE_DR;
    logic                TDO;
    logic                TDO_EN;

    modport slave (
        input  TMS, TDI, DR_TDO,
        output I_CODE, TAP_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO, TDO_EN
    );

    modport master (
        output TMS, TDI, DR_TDO,
        input  I_CODE, TAP_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO, TDO_EN
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine with instruction register, DR strobes and TDO mux.
// All state advances on the rising edge of TCK; RST is synchronous.
module tap_controller #(
    parameter int                  IR_WIDTH   = 3,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = 3'b001,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 3'b001
) (
    input  logic            TCK,
    input  logic            RST,
    tap_controller_if.slave tap
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    tap_state_t          state_reg, state_next;
    logic [IR_WIDTH-1:0] ir_shift_reg, ir_shift_next;
    logic [IR_WIDTH-1:0] i_code_reg, i_code_next;
    logic                tdo_reg, tdo_next;
    logic                tdo_en_reg, tdo_en_next;
    logic [IR_WIDTH-1:0] ir_shift_in;

    // LSB leaves on TDO first; TDI enters at the MSB.
    generate
        for (genvar gi = 0; gi < IR_WIDTH - 1; gi++) begin : g_ir_chain
            assign ir_shift_in[gi] = ir_shift_reg[gi+1];
        end
    endgenerate
    assign ir_shift_in[IR_WIDTH-1] = tap.TDI;

    always_ff @(posedge TCK) begin
        if (RST) begin
            state_reg    <= TLR;
            ir_shift_reg <= '0;
            i_code_reg   <= IR_RESET;
            tdo_reg      <= 1'b0;
            tdo_en_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ir_shift_reg <= ir_shift_next;
            i_code_reg   <= i_code_next;
            tdo_reg      <= tdo_next;
            tdo_en_reg   <= tdo_en_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ir_shift_next = ir_shift_reg;
        i_code_next   = i_code_reg;
        tdo_next      = 1'b0;
        tdo_en_next   = 1'b0;
        case (state_reg)
            TLR: begin
                state_next  = tap.TMS ? TLR : RTI;
                i_code_next = IR_RESET;
            end
            RTI:    state_next = tap.TMS ? SEL_DR : RTI;
            SEL_DR: state_next = tap.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tap.TMS ? EX1_DR : SH_DR;
            SH_DR: begin
                state_next  = tap.TMS ? EX1_DR : SH_DR;
                tdo_next    = tap.DR_TDO;
                tdo_en_next = 1'b1;
            end
            EX1_DR: state_next = tap.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_next = tap.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_next = tap.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_next = tap.TMS ? SEL_DR : RTI;
            SEL_IR: state_next = tap.TMS ? TLR : CAP_IR;
            CAP_IR: begin
                state_next    = tap.TMS ? EX1_IR : SH_IR;
                ir_shift_next = IR_CAPTURE;
            end
            SH_IR: begin
                state_next    = tap.TMS ? EX1_IR : SH_IR;
                ir_shift_next = ir_shift_in;
                tdo_next      = ir_shift_reg[0];
                tdo_en_next   = 1'b1;
            end
            EX1_IR: state_next = tap.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_next = tap.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_next = tap.TMS ? UPD_IR : SH_IR;
            UPD_IR: begin
                state_next  = tap.TMS ? SEL_DR : RTI;
                i_code_next = ir_shift_reg;
            end
            default: state_next = TLR;
        endcase
    end

    assign tap.TAP_STATE  = state_reg;
    assign tap.I_CODE     = i_code_reg;
    assign tap.CAPTURE_DR = (state_reg == CAP_DR);
    assign tap.SHIFT_DR   = (state_reg == SH_DR);
    assign tap.UPDATE_DR  = (state_reg == UPD_DR);
    assign tap.TDO        = tdo_reg;
    assign tap.TDO_EN     = tdo_en_reg;
endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: a table-driven TAP model predicts every cycle,
// a monitor compares registered outputs and pops TDO bits whenever TDO_EN is high.
module tb_tap_controller;
    logic TCK;
    logic RST;

    tap_controller_if #(.IR_WIDTH(3)) bus ();

    tap_controller #(
        .IR_WIDTH  (3),
        .IR_RESET  (3'b001),
        .IR_CAPTURE(3'b001)
    ) dut (
        .TCK(TCK),
        .RST(RST),
        .tap(bus.slave)
    );

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    typedef struct {
        logic [3:0] st;
        logic [2:0] ic;
        logic       cap;
        logic       sh;
        logic       upd;
        logic       en;
    } exp_t;

    exp_t exp_q[$];
    logic tdo_q[$];

    int checks = 0;
    int passes = 0;

    // Next-state tables indexed by the 1149.1 state code, for TMS=0 and TMS=1.
    int nxt0[16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                     4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    int nxt1[16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                     4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    int m_state = 15;
    int m_ir    = 0;
    int m_icode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input logic tms, input logic tdi, input logic dr, input logic rst);
        exp_t e;
        logic en;
        @(negedge TCK);
        bus.TMS = tms; bus.TDI = tdi; bus.DR_TDO = dr; RST = rst;
        en = 1'b0;
        if (rst) begin
            m_state = 15; m_ir = 0; m_icode = 1;
        end else begin
            if (m_state == 15) m_icode = 1;
            if (m_state == 14) m_ir = 1;
            if (m_state == 13) m_icode = m_ir;
            if (m_state == 10) begin
                tdo_q.push_back(m_ir[0]);
                en = 1'b1;
                m_ir = (m_ir >> 1) + (tdi ? 4 : 0);
            end
            if (m_state == 2) begin
                tdo_q.push_back(dr);
                en = 1'b1;
            end
            m_state = tms ? nxt1[m_state] : nxt0[m_state];
        end
        e.st  = 4'(m_state);
        e.ic  = 3'(m_icode);
        e.cap = (m_state == 6);
        e.sh  = (m_state == 2);
        e.upd = (m_state == 5);
        e.en  = en;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge TCK);
        #2;
    endtask

    task automatic go_ir_shift();   // from RTI to Shift-IR
        tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    endtask

    // Monitor: one expected record per edge, TDO data popped on each TDO_EN cycle.
    initial begin
        exp_t e;
        logic b;
        forever begin
            @(posedge TCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tap_state", 32'(bus.TAP_STATE), 32'(e.st));
                chk("i_code", 32'(bus.I_CODE), 32'(e.ic));
                chk("strobes", {29'b0, bus.CAPTURE_DR, bus.SHIFT_DR, bus.UPDATE_DR},
                    {29'b0, e.cap, e.sh, e.upd});
                chk("tdo_en", 32'(bus.TDO_EN), 32'(e.en));
                if (!e.en) chk("tdo_idle", 32'(bus.TDO), 32'd0);
            end
            if (bus.TDO_EN === 1'b1) begin
                if (tdo_q.size() == 0) begin
                    chk("tdo_unexpected", 32'(bus.TDO_EN), 32'd0);
                end else begin
                    b = tdo_q.pop_front();
                    chk("tdo_bit", 32'(bus.TDO), 32'(b));
                end
            end
        end
    end

    initial begin
        bus.TMS = 1'b1; bus.TDI = 1'b0; bus.DR_TDO = 1'b0; RST = 1'b1;
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);

        // Reset from Shift-DR.
        tick(0, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        settle();
        chk("rst_from_shdr_state", 32'(bus.TAP_STATE), 32'hF);
        chk("rst_from_shdr_icode", 32'(bus.I_CODE), 32'd1);
        chk("rst_from_shdr_tdo_en", 32'(bus.TDO_EN), 32'd0);

        // Five TMS=1 from RTI.
        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
        settle();
        chk("five_tms_tlr", 32'(bus.TAP_STATE), 32'hF);

        // Load EXTEST (000); captured 001 shifts out as 1,0,0.
        tick(0, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        settle();
        chk("extest_icode", 32'(bus.I_CODE), 32'd0);

        // DR scan with DR_TDO = 1,0,1.
        tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 1, 0); tick(0, 0, 0, 0); tick(1, 0, 1, 0);
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);

        // IR load 111 with a pause mid-shift.
        go_ir_shift();
        tick(0, 1, 0, 0); tick(1, 1, 0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        settle();
        chk("pause_icode_stable", 32'(bus.I_CODE), 32'd0);
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        settle();
        chk("load_111_icode", 32'(bus.I_CODE), 32'd7);

        // Reset after two IR bits, then a clean 101 scan.
        go_ir_shift();
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        settle();
        chk("rst_mid_ir_icode", 32'(bus.I_CODE), 32'd1);
        tick(0, 0, 0, 0);
        go_ir_shift();
        tick(0, 1, 0, 0); tick(0, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        settle();
        chk("clean_scan_icode", 32'(bus.I_CODE), 32'd5);

        // Random walk against the model.
        for (int i = 0; i < 2000; i++) begin
            tick(logic'($urandom_range(0, 99) < 35), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 199) == 0));
        end

        repeat (3) @(negedge TCK);
        chk("scoreboard_drained", 32'(exp_q.size() + tdo_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
